// File: rtl/al_accel_pkg.sv
// al_accel_pkg: shared types for the input-buffer window.
// Holds the window FSM state enum and the per-cycle bank command encoding.
package al_accel_pkg;
  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_WRITE, OP_SHIFT} op_t;
  // Bank command after priority resolution: a rotate suppresses shift but
  // not write (the write then lands on the rotated contents).
  function automatic op_t op_decode(input logic enb, input logic ld_wrn, input logic se_load);
    return !enb ? OP_NOP : ld_wrn ? OP_WRITE : se_load ? OP_NOP : OP_SHIFT;
  endfunction
endpackage

// File: rtl/al_accel_ibuf_bank.sv
// al_accel_ibuf_bank: one window row -- element array, fill counter, append/shift/rotate-in.
// Ports: clk, reset (sync, active-high); op/sel command for this bank; rot takes nb_e/nb_fill
// as the base contents before op applies; word/wstrb/init write data, skip count, pad value;
// e_q/fill_q registered contents; fill_d next fill. With AL_ACCEL_IBUF_ERR_EN an evt output
// flags overflow (truncated append) or underflow (shift while empty).
module al_accel_ibuf_bank
  import al_accel_pkg::*;
#(
  parameter int EW = 8,
  parameter int W = 4,
  parameter int BANK_E = 12,
  parameter int FW = 4,
  parameter int WSW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  op_t                  op,
  input  logic                 sel,
  input  logic                 rot,
  input  logic [BANK_E*EW-1:0] nb_e,
  input  logic [FW-1:0]        nb_fill,
  input  logic [W*EW-1:0]      word,
  input  logic [WSW-1:0]       wstrb,
  input  logic [EW-1:0]        init,
  output logic [BANK_E*EW-1:0] e_q,
  output logic [FW-1:0]        fill_q,
`ifdef AL_ACCEL_IBUF_ERR_EN
  output logic                 evt,
`endif
  output logic [FW-1:0]        fill_d
);
  logic [BANK_E*EW-1:0] base_e, e_d;
  logic [FW-1:0] base_fill;
  int f, s, n;
  always_comb begin
    base_e = rot ? nb_e : e_q;
    base_fill = rot ? nb_fill : fill_q;
    f = int'(base_fill);
    s = int'(wstrb);
    n = s >= W ? 0 : W - s;
    e_d = base_e;
    fill_d = base_fill;
`ifdef AL_ACCEL_IBUF_ERR_EN
    evt = 1'b0;
`endif
    if (op == OP_WRITE && sel) begin
      // slot i takes post-skip element (i - f); slots past BANK_E are dropped
      for (int i = 0; i < BANK_E; i++)
        if (i >= f && i < f + n) e_d[i*EW +: EW] = word[(s+i-f)*EW +: EW];
      fill_d = f + n > BANK_E ? FW'(BANK_E) : FW'(f + n);
`ifdef AL_ACCEL_IBUF_ERR_EN
      evt = f + n > BANK_E;
`endif
    end else if (op == OP_SHIFT) begin
      if (f != 0) begin
        e_d = {init, base_e[BANK_E*EW-1:EW]};
        fill_d = base_fill - 1'b1;
      end
`ifdef AL_ACCEL_IBUF_ERR_EN
      evt = f == 0;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      fill_q <= '0;
    end else begin
      e_q <= e_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/al_accel_ibuf_win.sv
// al_accel_ibuf_win: K-bank input buffer presenting a KxK element window.
// Ports: clk, reset (sync, active-high); enb qualifies all commands; ibuf_di/ibuf_ld_wrn/
// ibuf_bank_sel/ibuf_di_revert/ibuf_conv_wstrb describe an append (ld_wrn=1) or shift (0);
// ibuf_conv_se_load rotates rows down; ibuf_init pads vacated elements; ibuf_do is the window
// (bank r element c at slot r*K+c), ibuf_do_valid flags READY, ibuf_err is the sticky fault.
// Optional AL_ACCEL_IBUF_ERR_EN enables ibuf_err; otherwise it is tied 0.
module al_accel_ibuf_win
  import al_accel_pkg::*;
#(
  parameter int K = 3,
  parameter int DW = 32,
  parameter int EW = 8,
  parameter int BANK_E = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enb,
  input  logic [DW-1:0]          ibuf_di,
  input  logic                   ibuf_ld_wrn,
  input  logic [$clog2(K)-1:0]   ibuf_bank_sel,
  input  logic                   ibuf_di_revert,
  input  logic [$clog2(DW/EW):0] ibuf_conv_wstrb,
  input  logic                   ibuf_conv_se_load,
  input  logic [EW-1:0]          ibuf_init,
  output logic [K*K*EW-1:0]      ibuf_do,
  output logic                   ibuf_do_valid,
  output logic                   ibuf_err
);
  localparam int W = DW / EW;
  localparam int FW = $clog2(BANK_E + 1);
  localparam int SW = $clog2(K);
  logic [DW-1:0] word;
  logic [BANK_E*EW-1:0] e_q [K];
  logic [BANK_E*EW-1:0] nb_e [K];
  logic [FW-1:0] fill_q [K];
  logic [FW-1:0] fill_d [K];
  logic [FW-1:0] nb_fill [K];
  logic rot, all_z, all_k;
  op_t op;
  state_t state_q, state_d;
  assign op = op_decode(enb, ibuf_ld_wrn, ibuf_conv_se_load);
  assign rot = enb & ibuf_conv_se_load;
  always_comb begin
    word = '0;
    for (int i = 0; i < W; i++)
      word[i*EW +: EW] = ibuf_di_revert ? ibuf_di[DW-EW*(i+1) +: EW] : ibuf_di[EW*i +: EW];
  end
`ifdef AL_ACCEL_IBUF_ERR_EN
  logic [K-1:0] evt;
  always_ff @(posedge clk) begin
    if (reset) ibuf_err <= 1'b0;
    else if (|evt) ibuf_err <= 1'b1;
  end
`else
  assign ibuf_err = 1'b0;
`endif
  for (genvar r = 0; r < K; r++) begin : g_bank
    // rotate source: the row below, or a cleared row for the bottom bank
    if (r == K - 1) begin : g_last
      assign nb_e[r] = {BANK_E{ibuf_init}};
      assign nb_fill[r] = '0;
    end else begin : g_mid
      assign nb_e[r] = e_q[r+1];
      assign nb_fill[r] = fill_q[r+1];
    end
    al_accel_ibuf_bank #(.EW(EW), .W(W), .BANK_E(BANK_E), .FW(FW), .WSW(SW == 0 ? 1 : $clog2(W) + 1)) u_bank (
      .clk(clk),
      .reset(reset),
      .op(op),
      .sel(ibuf_bank_sel == SW'(r)),
      .rot(rot),
      .nb_e(nb_e[r]),
      .nb_fill(nb_fill[r]),
      .word(word),
      .wstrb(ibuf_conv_wstrb),
      .init(ibuf_init),
      .e_q(e_q[r]),
      .fill_q(fill_q[r]),
`ifdef AL_ACCEL_IBUF_ERR_EN
      .evt(evt[r]),
`endif
      .fill_d(fill_d[r])
    );
  end
  always_comb begin
    ibuf_do = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        ibuf_do[(r*K+c)*EW +: EW] = e_q[r][c*EW +: EW];
  end
  always_comb begin
    all_z = 1'b1;
    all_k = 1'b1;
    for (int r = 0; r < K; r++) begin
      all_z = all_z & (fill_d[r] == '0);
      all_k = all_k & (fill_d[r] >= FW'(K));
    end
    state_d = all_k ? READY : all_z ? IDLE : FILL;
  end
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  assign ibuf_do_valid = state_q == READY;
endmodule

// File: tb/tb_al_accel_ibuf_win.sv
// tb_al_accel_ibuf_win: directed plus random check of al_accel_ibuf_win against a behavioural model.
module tb_al_accel_ibuf_win;
  localparam int K = 3, DW = 32, EW = 8, BANK_E = 12, W = DW / EW;
`ifdef AL_ACCEL_IBUF_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, enb = 1'b0, ld_wrn = 1'b0, revert = 1'b0, se_load = 1'b0;
  logic [DW-1:0] di = '0;
  logic [1:0] sel = '0;
  logic [2:0] wstrb = '0;
  logic [EW-1:0] init = '0;
  logic [K*K*EW-1:0] ibuf_do;
  logic ibuf_do_valid, ibuf_err;
  int checks = 0, fails = 0;
  bit chk_en = 1'b0;
  logic [7:0] me [K][BANK_E];
  int mf [K];
  bit merr;
  always #5 clk = ~clk;
  al_accel_ibuf_win #(.K(K), .DW(DW), .EW(EW), .BANK_E(BANK_E)) dut (
    .clk(clk),
    .reset(reset),
    .enb(enb),
    .ibuf_di(di),
    .ibuf_ld_wrn(ld_wrn),
    .ibuf_bank_sel(sel),
    .ibuf_di_revert(revert),
    .ibuf_conv_wstrb(wstrb),
    .ibuf_conv_se_load(se_load),
    .ibuf_init(init),
    .ibuf_do(ibuf_do),
    .ibuf_do_valid(ibuf_do_valid),
    .ibuf_err(ibuf_err)
  );
  // model: each bank is a list of elements with a count of valid ones
  initial begin
    for (int r = 0; r < K; r++) begin
      mf[r] = 0;
      for (int i = 0; i < BANK_E; i++) me[r][i] = 8'h00;
    end
    merr = 1'b0;
  end
  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < K; r++) begin
        mf[r] = 0;
        for (int i = 0; i < BANK_E; i++) me[r][i] = 8'h00;
      end
      merr = 1'b0;
    end else if (enb) begin
      if (se_load) begin
        for (int r = 0; r < K - 1; r++) begin
          mf[r] = mf[r+1];
          for (int i = 0; i < BANK_E; i++) me[r][i] = me[r+1][i];
        end
        mf[K-1] = 0;
        for (int i = 0; i < BANK_E; i++) me[K-1][i] = init;
      end
      if (ld_wrn) begin
        if (int'(sel) < K)
          for (int j = int'(wstrb); j < W; j++) begin
            logic [31:0] t;
            t = revert ? di >> (DW - EW * (j + 1)) : di >> (EW * j);
            if (mf[sel] < BANK_E) begin
              me[sel][mf[sel]] = t[7:0];
              mf[sel] = mf[sel] + 1;
            end else merr = 1'b1;
          end
      end else if (!se_load) begin
        for (int r = 0; r < K; r++)
          if (mf[r] == 0) merr = 1'b1;
          else begin
            for (int i = 0; i < BANK_E - 1; i++) me[r][i] = me[r][i+1];
            me[r][BANK_E-1] = init;
            mf[r] = mf[r] - 1;
          end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      logic [K*K*EW-1:0] ew;
      bit ev;
      ev = 1'b1;
      for (int r = 0; r < K; r++) begin
        if (mf[r] < K) ev = 1'b0;
        for (int c = 0; c < K; c++) ew[(r*K+c)*EW +: EW] = me[r][c];
      end
      checks = checks + 3;
      if (ibuf_do !== ew) begin
        fails++;
        $display("FAIL model_win t=%0t got %h want %h", $time, ibuf_do, ew);
      end
      if (ibuf_do_valid !== ev) begin
        fails++;
        $display("FAIL model_valid t=%0t got %b want %b", $time, ibuf_do_valid, ev);
      end
      if (ibuf_err !== (merr & ERR_ON)) begin
        fails++;
        $display("FAIL model_err t=%0t got %b want %b", $time, ibuf_err, merr & ERR_ON);
      end
    end
  end
  task automatic chk(input string name, input logic [K*K*EW-1:0] act, input logic [K*K*EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic e, input logic [31:0] d, input logic ld,
                     input logic [1:0] s, input logic rv, input logic [2:0] ws, input logic se);
    reset = r; enb = e; di = d; ld_wrn = ld; sel = s; revert = rv; wstrb = ws; se_load = se;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] s, input logic [31:0] d, input logic rv, input logic [2:0] ws);
    cyc(1'b0, 1'b1, d, 1'b1, s, rv, ws, 1'b0);
  endtask
  task automatic sh();
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0);
  endtask
  initial begin
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0);
    chk("rst_do", ibuf_do, '0);
    chk("rst_valid", {71'd0, ibuf_do_valid}, 72'd0);
    chk("rst_err", {71'd0, ibuf_err}, 72'd0);
    wr(2'd0, 32'hE65E3709, 1'b0, 3'd0);
    chk("w1_valid", {71'd0, ibuf_do_valid}, 72'd0);
    wr(2'd1, 32'h5E154E18, 1'b0, 3'd0);
    wr(2'd2, 32'h553B070D, 1'b0, 3'd0);
    chk("w3_win", ibuf_do, 72'h3B070D_154E18_5E3709);
    chk("w3_valid", {71'd0, ibuf_do_valid}, 72'd1);
    sh();
    chk("sh1_row0", {48'd0, ibuf_do[23:0]}, 72'hE65E37);
    chk("sh1_valid", {71'd0, ibuf_do_valid}, 72'd1);
    sh();
    chk("sh2_row0", {48'd0, ibuf_do[23:0]}, 72'h00E65E);
    chk("sh2_valid", {71'd0, ibuf_do_valid}, 72'd0);
    wr(2'd0, 32'h06612524, 1'b1, 3'd3);
    chk("rev_row0", {48'd0, ibuf_do[23:0]}, 72'h24E65E);
    wr(2'd1, 32'h11223344, 1'b0, 3'd3);
    wr(2'd2, 32'h11223344, 1'b0, 3'd3);
    chk("refill_win", ibuf_do, 72'h11553B_115E15_24E65E);
    chk("refill_valid", {71'd0, ibuf_do_valid}, 72'd1);
    cyc(1'b0, 1'b1, 32'h38005B21, 1'b1, 2'd2, 1'b0, 3'd0, 1'b1);
    chk("rot_win", ibuf_do, 72'h005B21_11553B_115E15);
    chk("rot_valid", {71'd0, ibuf_do_valid}, 72'd1);
    chk("rot_err", {71'd0, ibuf_err}, 72'd0);
    wr(2'd2, 32'hA1A2A3A4, 1'b0, 3'd0);
    wr(2'd2, 32'hB1B2B3B4, 1'b0, 3'd2);
    chk("fill10_err", {71'd0, ibuf_err}, 72'd0);
    wr(2'd2, 32'hC1C2C3C4, 1'b0, 3'd0);
    chk("ovf_err", {71'd0, ibuf_err}, {71'd0, ERR_ON});
    sh();
    wr(2'd1, 32'h01020304, 1'b0, 3'd1);
    chk("ovf_err_held", {71'd0, ibuf_err}, {71'd0, ERR_ON});
    cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0);
    chk("rstw_do", ibuf_do, '0);
    chk("rstw_flags", {70'd0, ibuf_do_valid, ibuf_err}, 72'd0);
    sh();
    chk("udf_err", {71'd0, ibuf_err}, {71'd0, ERR_ON});
    for (int n = 0; n < 4000; n++) begin
      init = 8'($urandom);
      cyc($urandom_range(0, 249) == 0, $urandom_range(0, 9) != 0, $urandom,
          $urandom_range(0, 9) < 6, 2'($urandom), 1'($urandom), 3'($urandom_range(0, 5)),
          $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
